tholin_avalonsemi_5401: RTL and testbench

THOLIN_AVALONSEMI_5401 -- requirements
Module: tholin_avalonsemi_5401

---
 rtl/tholin_avalonsemi_5401_pkg.sv | 35 +++
 rtl/tholin_5401_alu.sv | 29 ++
 rtl/tholin_avalonsemi_5401.sv | 122 ++++++++++++
 tb/tb_tholin_avalonsemi_5401.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/tholin_avalonsemi_5401_pkg.sv
// Shared definitions for the 4-bit nibble CPU: opcodes, FSM encoding and
// the bus-cycle formats seen on io_out.
package tholin_avalonsemi_5401_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDI = 4'h1;
   localparam logic [3:0] OP_LD  = 4'h2;
   localparam logic [3:0] OP_ST  = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SUB = 4'h6;
   localparam logic [3:0] OP_AND = 4'h7;
   localparam logic [3:0] OP_OR  = 4'h8;
   localparam logic [3:0] OP_XOR = 4'h9;
   localparam logic [3:0] OP_NOT = 4'hA;
   localparam logic [3:0] OP_IN  = 4'hB;
   localparam logic [3:0] OP_OUT = 4'hC;
   localparam logic [3:0] OP_JMP = 4'hD;
   localparam logic [3:0] OP_JC  = 4'hE;
   localparam logic [3:0] OP_JZ  = 4'hF;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_OPER1 = 2'd1,
      ST_OPER2 = 2'd2,
      ST_IO    = 2'd3
   } state_e;

   // io_out[7] selects between a ROM address cycle and an I/O cycle
   localparam logic       ADDR_CYCLE     = 1'b0;
   localparam logic       IO_CYCLE       = 1'b1;
   localparam logic [7:0] IO_IN_PATTERN  = 8'hF0;
   localparam logic [2:0] OUT_PORT_NONE  = 3'd7;

endpackage

// File: rtl/tholin_5401_alu.sv
// Combinational 4-bit ALU; carry/borrow out passes the incoming flag through
// for operations that do not produce one.
module tholin_5401_alu
   import tholin_avalonsemi_5401_pkg::*;
(
   input  logic [3:0] op_i,
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       c_i,
   output logic [3:0] y_o,
   output logic       c_o
);

   always_comb begin
      y_o = a_i;
      c_o = c_i;
      case (op_i)
         OP_ADD: {c_o, y_o} = {1'b0, a_i} + {1'b0, b_i};
         OP_ADC: {c_o, y_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
         OP_SUB: {c_o, y_o} = {1'b0, a_i} - {1'b0, b_i};
         OP_AND: y_o = a_i & b_i;
         OP_OR:  y_o = a_i | b_i;
         OP_XOR: y_o = a_i ^ b_i;
         OP_NOT: y_o = ~a_i;
         default: ;
      endcase
   end

endmodule

// File: rtl/tholin_avalonsemi_5401.sv
// Nibble-serial 4-bit CPU fetching from an external combinational ROM and
// doing port I/O over the same 8-bit bus.
//
//   state    | meaning
//   FETCH    | drive PC, latch opcode, execute NOP/NOT
//   OPER1    | drive PC, latch first operand, execute 2-nibble ops
//   OPER2    | drive PC, take low jump nibble, resolve jump
//   IO       | bus shows IN pattern or OUT port/value; PC holds
module tholin_avalonsemi_5401
   import tholin_avalonsemi_5401_pkg::*;
(
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   logic       clk;
   logic       rst_n;
   logic [3:0] data_in;
   logic       unused_io;

   assign clk       = io_in[0];
   assign rst_n     = io_in[1];
   assign data_in   = io_in[5:2];
   assign unused_io = ^io_in[7:6];

   state_e     state_q;
   logic [6:0] pc_q;
   logic [3:0] a_q;
   logic       c_q;
   logic [3:0] op_q;
   logic [2:0] opr_q;
   logic [3:0] regs_q [8];

   logic [3:0] alu_op;
   logic [3:0] alu_y;
   logic       alu_c;
   logic       jump_taken;

   // NOT executes during FETCH before the opcode is latched
   assign alu_op = (state_q == ST_FETCH) ? data_in : op_q;

   tholin_5401_alu u_alu (
      .op_i (alu_op),
      .a_i  (a_q),
      .b_i  (regs_q[data_in[2:0]]),
      .c_i  (c_q),
      .y_o  (alu_y),
      .c_o  (alu_c)
   );

   always_comb begin
      jump_taken = 1'b0;
      case (op_q)
         OP_JMP:  jump_taken = 1'b1;
         OP_JC:   jump_taken = c_q;
         OP_JZ:   jump_taken = (a_q == 4'h0);
         default: jump_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         pc_q    <= 7'd0;
         a_q     <= 4'h0;
         c_q     <= 1'b0;
         op_q    <= 4'h0;
         opr_q   <= 3'd0;
         for (int i = 0; i < 8; i++) regs_q[i] <= 4'h0;
      end else begin
         case (state_q)
            ST_FETCH: begin
               op_q <= data_in;
               pc_q <= pc_q + 7'd1;
               case (data_in)
                  OP_NOP:  state_q <= ST_FETCH;
                  OP_NOT: begin
                     a_q     <= alu_y;
                     state_q <= ST_FETCH;
                  end
                  OP_IN:   state_q <= ST_IO;
                  default: state_q <= ST_OPER1;
               endcase
            end
            ST_OPER1: begin
               opr_q   <= data_in[2:0];
               pc_q    <= pc_q + 7'd1;
               state_q <= ST_FETCH;
               case (op_q)
                  OP_LDI: a_q <= data_in;
                  OP_LD:  a_q <= regs_q[data_in[2:0]];
                  OP_ST:  regs_q[data_in[2:0]] <= a_q;
                  OP_ADD, OP_ADC, OP_SUB: begin
                     a_q <= alu_y;
                     c_q <= alu_c;
                  end
                  OP_AND, OP_OR, OP_XOR: a_q <= alu_y;
                  OP_OUT: if (data_in[2:0] != OUT_PORT_NONE) state_q <= ST_IO;
                  OP_JMP, OP_JC, OP_JZ: state_q <= ST_OPER2;
                  default: ;
               endcase
            end
            ST_OPER2: begin
               state_q <= ST_FETCH;
               pc_q    <= jump_taken ? {opr_q, data_in} : pc_q + 7'd1;
            end
            ST_IO: begin
               state_q <= ST_FETCH;
               if (op_q == OP_IN) a_q <= data_in;
            end
            default: state_q <= ST_FETCH;
         endcase
      end
   end

   always_comb begin
      io_out = {ADDR_CYCLE, pc_q};
      if (state_q == ST_IO)
         io_out = (op_q == OP_IN) ? IO_IN_PATTERN : {IO_CYCLE, opr_q, a_q};
   end

endmodule

// File: tb/tb_tholin_avalonsemi_5401.sv
// Bench for the nibble CPU: an instruction-level interpreter predicts the bus
// trace, a monitor compares io_out against it cycle by cycle.
module tb_tholin_avalonsemi_5401;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] io_data;
   logic [3:0] rom_nib;
   logic [7:0] io_in;
   logic [7:0] io_out;
   logic [3:0] rom [128];

   int         tests = 0;
   int         fails = 0;
   int         cyc;
   bit         mon_en = 1'b0;
   string      tname;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   assign rom_nib = io_out[7] ? io_data : rom[io_out[6:0]];
   assign io_in   = {2'b00, rom_nib, rst_n, clk};

   tholin_avalonsemi_5401 dut (
      .io_in  (io_in),
      .io_out (io_out)
   );

   // Interpreter: runs whole instructions and records every bus cycle.
   task automatic build_trace(input int n, input logic [3:0] in_val);
      int pc, a, c, op, x, lo, rv;
      int r [8];
      bit taken;
      pc = 0; a = 0; c = 0;
      for (int i = 0; i < 8; i++) r[i] = 0;
      while (exp_q.size() < n) begin
         op = int'(rom[pc]);
         exp_q.push_back(8'(pc));
         pc = (pc + 1) % 128;
         if (op == 0) begin
         end else if (op == 10) begin
            a = 15 - a;
         end else if (op == 11) begin
            exp_q.push_back(8'hF0);
            a = int'(in_val);
         end else begin
            exp_q.push_back(8'(pc));
            x  = int'(rom[pc]);
            pc = (pc + 1) % 128;
            rv = r[x % 8];
            case (op)
               1: a = x;
               2: a = rv;
               3: r[x % 8] = a;
               4: begin a = a + rv;     c = a / 16; a = a % 16; end
               5: begin a = a + rv + c; c = a / 16; a = a % 16; end
               6: begin c = (a < rv) ? 1 : 0; a = (a - rv + 16) % 16; end
               7: a = a & rv;
               8: a = a | rv;
               9: a = a ^ rv;
               12: if (x % 8 != 7) exp_q.push_back(8'(128 + (x % 8) * 16 + a));
               default: begin
                  exp_q.push_back(8'(pc));
                  lo = int'(rom[pc]);
                  pc = (pc + 1) % 128;
                  taken = (op == 13) || (op == 14 && c == 1) || (op == 15 && a == 0);
                  if (taken) pc = (x % 8) * 16 + lo;
               end
            endcase
         end
      end
      while (exp_q.size() > n) void'(exp_q.pop_back());
   endtask

   always @(negedge clk) begin
      logic [7:0] e;
      if (mon_en) begin
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (io_out !== e) begin
               fails++;
               $display("FAIL %s cycle %0d: io_out=%02h expected %02h", tname, cyc, io_out, e);
            end
            cyc++;
         end
      end
   end

   task automatic check(input string what, input logic [7:0] act, input logic [7:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: io_out=%02h expected %02h", what, act, req);
      end
   endtask

   task automatic load_hex(input string s);
      byte ch;
      for (int i = 0; i < 128; i++) rom[i] = 4'h0;
      for (int i = 0; i < s.len(); i++) begin
         ch = s.getc(i);
         rom[i] = (ch >= 8'h41) ? 4'(ch - 8'h37) : 4'(ch - 8'h30);
      end
   endtask

   task automatic run_prog(input string name, input int n, input logic [3:0] inv);
      tname   = name;
      cyc     = 0;
      rst_n   = 1'b0;
      io_data = inv;
      #1 check({name, " reset"}, io_out, 8'h00);
      @(posedge clk);
      #2;
      build_trace(n, inv);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      for (int k = 0; k < n + 10 && exp_q.size() > 0; k++) @(posedge clk);
      #2;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s timeout: %0d cycles left, expected 0", name, exp_q.size());
         exp_q.delete();
      end
      mon_en = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time exceeded, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      io_data = 4'h0;
      load_hex("");
      repeat (2) @(posedge clk);

      load_hex("");
      run_prog("nop_wrap", 260, 4'h0);
      load_hex("15301340C2");
      run_prog("add_out", 20, 4'h0);
      load_hex("1F311141E00");
      run_prog("carry_jc", 40, 4'h0);
      load_hex("BC0");
      run_prog("in_out", 12, 4'h9);
      load_hex("13331263F55C1");
      run_prog("sub_jz", 20, 4'h0);

      // reset in OPER1 of LDI 7, then show A is still 0
      load_hex("17C0");
      rst_n = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #2 check("midrst oper1", io_out, 8'h01);
      rst_n = 1'b0;
      #1 check("midrst async", io_out, 8'h00);
      load_hex("C0");
      run_prog("midrst restart", 8, 4'h0);

      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < 128; i++) rom[i] = 4'($urandom_range(0, 15));
         run_prog($sformatf("random%0d", t), 200, 4'($urandom_range(0, 15)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
